cdiv_seq: RTL and testbench

Operand sequencer and result capture controller for the complex divider. Accepts the four 32-bit operands over a valid/ready word stream and holds them stable on the divider inputs with the enable asserted for the divider's pipeline latency. It then samples the divider's 64-bit result and presents it downstream as separate real and imaginary words on a valid/ready handshake.

---
 rtl/cdiv_seq.sv | 162 ++++++++++++++++
 tb/tb_cdiv_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdiv_seq.sv
// cdiv_seq: operand sequencer and result capture controller for the complex divider.
// Collects four operand words (Real_A, Im_A, Real_B, Im_B) from a valid/ready stream,
// holds them on the divider with the enable high for LATENCY+1 cycles, captures the
// 64-bit result and offers it downstream as real/imaginary words.
// Optional feature: define CDIV_ZERO_CHECK_EN to short-circuit zero divisors
// (result forced to zero, div_zero flagged, divider never enabled).
module cdiv_seq #(
  parameter int LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        complex_real,
  output logic [31:0] Real_A,
  output logic [31:0] Im_A,
  output logic [31:0] Real_B,
  output logic [31:0] Im_B,
  input  logic [63:0] div_out,
  output logic [31:0] res_real,
  output logic [31:0] res_im,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        div_zero,
  output logic        busy
);

  localparam int RCNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [RCNT_W-1:0] RLAST = RCNT_W'(LATENCY);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        wcnt;
  logic [RCNT_W-1:0] rcnt;
  logic              word_hs;
  logic              last_word;
  logic              run_last;
  logic              zero_hit;

  // Handshake qualifiers come from registered state, never from in_ready's decode path.
  assign word_hs   = in_valid && (state == LOAD);
  assign last_word = word_hs && (wcnt == 2'd3);
  assign run_last  = (state == RUN) && (rcnt == RLAST);

`ifdef CDIV_ZERO_CHECK_EN
  logic dz_q;

  // A zero divisor is detected on the final word: Im_B arrives now, Real_B is already stored.
  assign zero_hit = last_word && (in_data == 32'd0) && (Real_B == 32'd0);
  assign div_zero = dz_q;

  // Zero-divisor flag: set by the bypass, cleared by a normal capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      dz_q <= 1'b0;
    end else if (zero_hit) begin
      dz_q <= 1'b1;
    end else if (run_last) begin
      dz_q <= 1'b0;
    end
  end
`else
  assign zero_hit = 1'b0;
  assign div_zero = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: if (last_word) state_nxt = zero_hit ? DONE : RUN;
      RUN:  if (run_last)  state_nxt = DONE;
      DONE: if (res_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Output decode, purely from the registered state.
  always_comb begin
    in_ready     = 1'b0;
    complex_real = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b0;
    unique case (state)
      LOAD: in_ready = 1'b1;
      RUN: begin
        complex_real = 1'b1;
        busy         = 1'b1;
      end
      DONE: begin
        res_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand loading, run counting and result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt     <= 2'd0;
      rcnt     <= '0;
      Real_A   <= 32'd0;
      Im_A     <= 32'd0;
      Real_B   <= 32'd0;
      Im_B     <= 32'd0;
      res_real <= 32'd0;
      res_im   <= 32'd0;
    end else begin
      unique case (state)
        LOAD: begin
          if (word_hs) begin
            unique case (wcnt)
              2'd0: Real_A <= in_data;
              2'd1: Im_A   <= in_data;
              2'd2: Real_B <= in_data;
              default: Im_B <= in_data;
            endcase
            wcnt <= wcnt + 2'd1;
          end
          if (last_word) begin
            rcnt <= '0;
          end
          if (zero_hit) begin
            res_real <= 32'd0;
            res_im   <= 32'd0;
          end
        end
        RUN: begin
          rcnt <= rcnt + RCNT_W'(1);
          if (run_last) begin
            res_real <= div_out[63:32];
            res_im   <= div_out[31:0];
          end
        end
        DONE: begin
          if (res_ready) begin
            wcnt <= 2'd0;
          end
        end
        default: wcnt <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cdiv_seq.sv
// Bench for cdiv_seq: table-driven operations, hand-written reset and stream-gap
// sequences, and randomized operations checked against a result/latency model.
module tb_cdiv_seq;

  localparam int LAT = 3;
`ifdef CDIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        complex_real;
  logic [31:0] Real_A, Im_A, Real_B, Im_B;
  logic [63:0] div_out;
  logic [31:0] res_real, res_im;
  logic        res_valid;
  logic        res_ready;
  logic        div_zero;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  cdiv_seq #(.LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .complex_real(complex_real),
    .Real_A(Real_A), .Im_A(Im_A), .Real_B(Real_B), .Im_B(Im_B),
    .div_out(div_out),
    .res_real(res_real), .res_im(res_im), .res_valid(res_valid), .res_ready(res_ready),
    .div_zero(div_zero), .busy(busy)
  );

  always #5 clock = ~clock;

  // Divider stub: result only during the cycle ending with edge LAT+1 after enable rises.
  int          stub_cnt = 0;
  logic [63:0] stub_val = 64'd0;
  always @(posedge clock) stub_cnt <= complex_real ? stub_cnt + 1 : 0;
  assign div_out = (complex_real && stub_cnt == LAT) ? stub_val : 64'd0;

  typedef struct {
    logic [31:0] w0, w1, w2, w3;
    logic [63:0] stub;
    logic [31:0] er, ei;
    logic        ed;
    int          hold;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Expected {div_zero, real, imag} for one operation.
  function automatic logic [64:0] ref_result(input logic [31:0] rb, input logic [31:0] ib,
                                             input logic [63:0] sv);
    if (ZCHK && rb == 32'd0 && ib == 32'd0) return {1'b1, 64'd0};
    return {1'b0, sv};
  endfunction

  task automatic send_word(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_complex_real"}, complex_real, 0);
    chk({tag, "_Real_A"}, Real_A, 0);
    chk({tag, "_Im_A"}, Im_A, 0);
    chk({tag, "_Real_B"}, Real_B, 0);
    chk({tag, "_Im_B"}, Im_B, 0);
    chk({tag, "_res_real"}, res_real, 0);
    chk({tag, "_res_im"}, res_im, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_div_zero"}, div_zero, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Called at the negedge after the 4th handshake edge.
  task automatic finish_op(input logic [127:0] ops, input logic [31:0] er, input logic [31:0] ei,
                           input logic ed, input int hold);
    int n;
    int crc;
    n = 0;
    crc = 0;
    chk("in_ready_after_load", in_ready, 0);
    chk("Real_A", Real_A, ops[127:96]);
    chk("Im_A", Im_A, ops[95:64]);
    chk("Real_B", Real_B, ops[63:32]);
    chk("Im_B", Im_B, ops[31:0]);
    while (res_valid !== 1'b1 && n < 64) begin
      if (complex_real === 1'b1) crc++;
      step();
      n++;
    end
    chk("res_valid_latency", n, ed ? 0 : LAT + 1);
    chk("enable_cycles", crc, ed ? 0 : LAT + 1);
    chk("res_real", res_real, er);
    chk("res_im", res_im, ei);
    chk("div_zero", div_zero, ed);
    chk("busy_done", busy, 1);
    chk("complex_real_done", complex_real, 0);
    in_valid = 1'b1;
    in_data  = 32'd7;
    for (int i = 0; i < hold; i++) step();
    chk("res_real_held", res_real, er);
    chk("res_im_held", res_im, ei);
    chk("res_valid_held", res_valid, 1);
    chk("Real_A_not_overwritten", Real_A, ops[127:96]);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    in_valid  = 1'b0;
    chk("in_ready_after_release", in_ready, 1);
    chk("res_valid_after_release", res_valid, 0);
    chk("busy_after_release", busy, 0);
    chk("Real_A_word_not_taken", Real_A, ops[127:96]);
  endtask

  task automatic run_op(input vec_t v, input int gapmax);
    stub_val = v.stub;
    foreach (v.w0[i]) begin end
    repeat ($urandom_range(gapmax)) step();
    send_word(v.w0);
    repeat ($urandom_range(gapmax)) step();
    send_word(v.w1);
    repeat ($urandom_range(gapmax)) step();
    send_word(v.w2);
    repeat ($urandom_range(gapmax)) step();
    send_word(v.w3);
    finish_op({v.w0, v.w1, v.w2, v.w3}, v.er, v.ei, v.ed, v.hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [64:0] r;
    logic pat[7];

    tbl[0] = '{32'd10, 32'd20, 32'd3, 32'd4, 64'h0000_0005_FFFF_FFFE,
               32'd5, 32'hFFFF_FFFE, 1'b0, 10};
    tbl[1] = '{32'd9, 32'd9, 32'd0, 32'd0, 64'h0000_0005_FFFF_FFFE,
               ZCHK ? 32'd0 : 32'd5, ZCHK ? 32'd0 : 32'hFFFF_FFFE, ZCHK, 2};
    tbl[2] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd7, 64'h1234_5678_9ABC_DEF0,
               32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0};
    tbl[3] = '{32'd0, 32'd0, 32'd5, 32'd0, 64'hDEAD_BEEF_0000_0001,
               32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    res_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_reset_state("reset");

    for (int i = 0; i < 4; i++) run_op(tbl[i], 0);

    // Reset after two accepted words discards the partial set.
    send_word(32'd11);
    send_word(32'd12);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("reset_mid_load");
    v = '{32'd1, 32'd2, 32'd3, 32'd4, 64'h0000_0001_0000_0002, 32'd1, 32'd2, 1'b0, 0};
    run_op(v, 0);

    // Reset during RUN aborts without capture.
    stub_val = 64'hAAAA_AAAA_5555_5555;
    send_word(32'd5);
    send_word(32'd6);
    send_word(32'd7);
    send_word(32'd8);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("reset_mid_run");
    repeat (LAT + 3) step();
    chk("no_capture_after_abort_valid", res_valid, 0);
    chk("no_capture_after_abort_real", res_real, 0);

    // Gapped stream: only the valid cycles store, in order.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    stub_val = 64'h0000_0042_0000_0024;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_data  = 32'd100 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    finish_op({32'd100, 32'd103, 32'd105, 32'd106}, 32'h42, 32'h24, 1'b0, 1);

    // Randomized operations against the reference model.
    for (int k = 0; k < 24; k++) begin
      int sel;
      sel  = $urandom_range(3);
      v.w0 = $urandom;
      v.w1 = $urandom;
      v.w2 = (sel <= 1) ? 32'd0 : $urandom;
      v.w3 = (sel == 0) ? 32'd0 : $urandom;
      v.stub = {$urandom, $urandom};
      r = ref_result(v.w2, v.w3, v.stub);
      v.ed = r[64];
      v.er = r[63:32];
      v.ei = r[31:0];
      v.hold = $urandom_range(3);
      run_op(v, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
